// File: rtl/unsigned_seq_div_rs_pkg.sv
// Shared constants for the sequential arithmetic blocks (divider, multiplier).
package seq_arith_pkg;

   localparam int ARITH_W = 6;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_RUN  = ST_RUN,
      S_DONE = ST_DONE
   } seq_state_t;

endpackage

// File: rtl/unsigned_seq_div_rs_if.sv
// Load/poll bus for the unsigned sequential divider.
interface unsigned_seq_div_rs_if
   import seq_arith_pkg::*;
#(
   parameter int WIDTH = ARITH_W
);
   logic                 load;
   logic [2*WIDTH-1:0]   dividend;
   logic [WIDTH-1:0]     divisor;
   logic [WIDTH-1:0]     quotient;
   logic [WIDTH-1:0]     remainder;
   logic                 busy;
   logic                 done;
   logic                 div_by_zero;
   logic                 overflow;

   modport master (
      output load, dividend, divisor,
      input  quotient, remainder, busy, done, div_by_zero, overflow
   );

   modport slave (
      input  load, dividend, divisor,
      output quotient, remainder, busy, done, div_by_zero, overflow
   );

endinterface

// File: rtl/unsigned_seq_div_rs_step.sv
// One restoring-division iteration: shift {R,Q} left, trial-subtract D.
module seq_div_step #(
   parameter int WIDTH = 6
) (
   input  logic [WIDTH:0]   r,
   input  logic [WIDTH-1:0] q,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH:0]   r_next,
   output logic [WIDTH-1:0] q_next
);
   logic [WIDTH:0]   r_sh;
   logic [WIDTH+1:0] diff;
   logic             neg;

   // R stays below D, so the shifted remainder always fits in WIDTH+1 bits.
   always_comb begin
      r_sh   = {r[WIDTH-1:0], q[WIDTH-1]};
      diff   = {1'b0, r_sh} - {2'b00, d};
      neg    = diff[WIDTH+1];
      r_next = neg ? r_sh : diff[WIDTH:0];
      q_next = {q[WIDTH-2:0], ~neg};
   end

endmodule

// File: rtl/unsigned_seq_div_rs.sv
// Unsigned sequential restoring divider, one quotient bit per clock.
// Optional debug build: define SEQ_DIV_DBG_EN to add dbg_count/dbg_state
// ports and a simulation check of q*d+r == dividend on each clean result.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | no result yet since reset; waiting for load
// S_RUN  | iterating (busy=1), or one-cycle settle of a flagged result
// S_DONE | result held on outputs until next load
module unsigned_seq_div_rs
   import seq_arith_pkg::*;
#(
   parameter  int WIDTH = ARITH_W,
   localparam int CW    = $clog2(WIDTH+1)
) (
   input  logic                  clk,
   input  logic                  rst,
   unsigned_seq_div_rs_if.slave  bus
`ifdef SEQ_DIV_DBG_EN
   ,
   output logic [CW-1:0]         dbg_count,
   output logic [1:0]            dbg_state
`endif
);
   seq_state_t       state, state_n;
   logic [CW-1:0]    cnt, cnt_n;
   logic [WIDTH:0]   r, r_n;
   logic [WIDTH-1:0] q, q_n;
   logic [WIDTH-1:0] d, d_n;
   logic [WIDTH-1:0] quot, quot_n;
   logic [WIDTH-1:0] rem, rem_n;
   logic             busy, busy_n;
   logic             done, done_n;
   logic             dbz, dbz_n;
   logic             ovf, ovf_n;
   logic             pend_dbz, pend_dbz_n;
   logic             pend_ovf, pend_ovf_n;

   logic [WIDTH:0]   step_r;
   logic [WIDTH-1:0] step_q;
   logic [WIDTH-1:0] hi, lo;

   assign hi = bus.dividend[2*WIDTH-1:WIDTH];
   assign lo = bus.dividend[WIDTH-1:0];

   seq_div_step #(.WIDTH(WIDTH)) u_step (
      .r      (r),
      .q      (q),
      .d      (d),
      .r_next (step_r),
      .q_next (step_q)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_n;
   end

   // Next-state and datapath decisions.
   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      r_n        = r;
      q_n        = q;
      d_n        = d;
      quot_n     = quot;
      rem_n      = rem;
      busy_n     = busy;
      done_n     = done;
      dbz_n      = dbz;
      ovf_n      = ovf;
      pend_dbz_n = pend_dbz;
      pend_ovf_n = pend_ovf;
      case (state)
         S_IDLE, S_DONE: begin
            if (bus.load) begin
               done_n = 1'b0;
               dbz_n  = 1'b0;
               ovf_n  = 1'b0;
               q_n    = lo;
               state_n = S_RUN;
               if (bus.divisor == '0) begin
                  // Flagged results settle one cycle after the load edge so
                  // done always shows a low cycle between operations.
                  pend_dbz_n = 1'b1;
                  cnt_n      = '0;
               end else if (hi >= bus.divisor) begin
                  pend_ovf_n = 1'b1;
                  cnt_n      = '0;
               end else begin
                  r_n    = {1'b0, hi};
                  d_n    = bus.divisor;
                  cnt_n  = CW'(WIDTH);
                  busy_n = 1'b1;
               end
            end
         end
         S_RUN: begin
            if (pend_dbz || pend_ovf) begin
               done_n     = 1'b1;
               dbz_n      = pend_dbz;
               ovf_n      = pend_ovf;
               quot_n     = '1;
               rem_n      = pend_dbz ? q : '0;
               pend_dbz_n = 1'b0;
               pend_ovf_n = 1'b0;
               state_n    = S_DONE;
            end else begin
               r_n   = step_r;
               q_n   = step_q;
               cnt_n = cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  quot_n  = step_q;
                  rem_n   = step_r[WIDTH-1:0];
                  busy_n  = 1'b0;
                  done_n  = 1'b1;
                  state_n = S_DONE;
               end
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         r        <= '0;
         q        <= '0;
         d        <= '0;
         quot     <= '0;
         rem      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         dbz      <= 1'b0;
         ovf      <= 1'b0;
         pend_dbz <= 1'b0;
         pend_ovf <= 1'b0;
      end else begin
         cnt      <= cnt_n;
         r        <= r_n;
         q        <= q_n;
         d        <= d_n;
         quot     <= quot_n;
         rem      <= rem_n;
         busy     <= busy_n;
         done     <= done_n;
         dbz      <= dbz_n;
         ovf      <= ovf_n;
         pend_dbz <= pend_dbz_n;
         pend_ovf <= pend_ovf_n;
      end
   end

   assign bus.quotient    = quot;
   assign bus.remainder   = rem;
   assign bus.busy        = busy;
   assign bus.done        = done;
   assign bus.div_by_zero = dbz;
   assign bus.overflow    = ovf;

`ifdef SEQ_DIV_DBG_EN
   assign dbg_count = cnt;
   assign dbg_state = state;

   logic [2*WIDTH-1:0] dvd_cap;
   logic [WIDTH-1:0]   dvs_cap;
   logic               done_d;

   // Operand copy and done history for the invariant check.
   always_ff @(posedge clk) begin
      if (rst) begin
         dvd_cap <= '0;
         dvs_cap <= '0;
         done_d  <= 1'b0;
      end else begin
         if ((state == S_IDLE || state == S_DONE) && bus.load) begin
            dvd_cap <= bus.dividend;
            dvs_cap <= bus.divisor;
         end
         done_d <= done;
      end
   end

`ifndef SYNTHESIS
   // On a fresh clean result, q*d+r must rebuild the dividend with r < d.
   always @(posedge clk) begin
      if (!rst && done && !done_d && !dbz && !ovf) begin
         if (({{WIDTH{1'b0}}, quot} * {{WIDTH{1'b0}}, dvs_cap})
             + {{WIDTH{1'b0}}, rem} != dvd_cap || rem >= dvs_cap)
            $error("divider invariant broken: q=%0d r=%0d d=%0d n=%0d",
                   quot, rem, dvs_cap, dvd_cap);
      end
   end
`endif
`endif

endmodule

// File: tb/tb_unsigned_seq_div_rs.sv
// Scoreboard bench for unsigned_seq_div_rs (WIDTH=6).
module tb_unsigned_seq_div_rs;
   import seq_arith_pkg::*;

   localparam int W = 6;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   unsigned_seq_div_rs_if #(.WIDTH(W)) bus ();

`ifdef SEQ_DIV_DBG_EN
   logic [2:0] dbg_count;
   logic [1:0] dbg_state;
`endif

   unsigned_seq_div_rs #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef SEQ_DIV_DBG_EN
      ,
      .dbg_count (dbg_count),
      .dbg_state (dbg_state)
`endif
   );

   typedef struct {
      string        nm;
      logic [W-1:0] q;
      logic [W-1:0] r;
      logic         dbz;
      logic         ovf;
      int           at;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   n_pass = 0;
   int   n_chk  = 0;
   int   cyc    = 0;
   logic done_d = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0d, required %0d", nm, act, req);
   endtask

   // Monitor: each fresh done is matched against the oldest expectation.
   always @(negedge clk) begin
      if (bus.done && !done_d) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", {31'd0, bus.done}, 32'd0);
         end else begin
            e = sb.pop_front();
            chk({e.nm, "_quotient"},  {26'd0, bus.quotient},  {26'd0, e.q});
            chk({e.nm, "_remainder"}, {26'd0, bus.remainder}, {26'd0, e.r});
            chk({e.nm, "_dbz"},       {31'd0, bus.div_by_zero}, {31'd0, e.dbz});
            chk({e.nm, "_ovf"},       {31'd0, bus.overflow},  {31'd0, e.ovf});
            chk({e.nm, "_cycle"},     cyc, e.at);
         end
      end
      done_d = bus.done;
   end

   // One-cycle load pulse; afterwards the inputs are scrambled to prove capture.
   task automatic issue(input string nm, input logic [2*W-1:0] dvd, input logic [W-1:0] dvs,
                        input bit push, input logic [W-1:0] q, input logic [W-1:0] r,
                        input logic dbz, input logic ovf, input int lat);
      exp_t x;
      @(negedge clk);
      bus.load     = 1'b1;
      bus.dividend = dvd;
      bus.divisor  = dvs;
      if (push) begin
         x.nm = nm; x.q = q; x.r = r; x.dbz = dbz; x.ovf = ovf; x.at = cyc + 1 + lat;
         sb.push_back(x);
      end
      @(negedge clk);
      bus.load     = 1'b0;
      bus.dividend = 12'hABC;
      bus.divisor  = 6'd1;
   endtask

   task automatic wait_done(input string nm, input int budget);
      int k = 0;
      while (!bus.done && k < budget) begin
         @(negedge clk);
         k++;
      end
      if (!bus.done) chk({nm, "_timeout"}, {31'd0, bus.done}, 32'd1);
      @(negedge clk);
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_quotient"},  {26'd0, bus.quotient},  32'd0);
      chk({nm, "_remainder"}, {26'd0, bus.remainder}, 32'd0);
      chk({nm, "_busy"},      {31'd0, bus.busy},      32'd0);
      chk({nm, "_done"},      {31'd0, bus.done},      32'd0);
      chk({nm, "_dbz"},       {31'd0, bus.div_by_zero}, 32'd0);
      chk({nm, "_ovf"},       {31'd0, bus.overflow},  32'd0);
   endtask

   initial begin
      rst          = 1'b1;
      bus.load     = 1'b0;
      bus.dividend = '0;
      bus.divisor  = '0;
      repeat (3) @(negedge clk);
      chk_zero("reset");
      rst = 1'b0;

      issue("d3969_63", 12'd3969, 6'd63, 1'b1, 6'd63, 6'd0, 1'b0, 1'b0, 6);
      wait_done("d3969_63", 12);

      issue("d100_7", 12'd100, 6'd7, 1'b1, 6'd14, 6'd2, 1'b0, 1'b0, 6);
      for (int i = 0; i < 6; i++) begin
         chk("d100_7_busy", {31'd0, bus.busy}, 32'd1);
         chk("d100_7_notdone", {31'd0, bus.done}, 32'd0);
         @(negedge clk);
      end
      wait_done("d100_7", 4);
      for (int i = 0; i < 3; i++) begin
         chk("hold_done",      {31'd0, bus.done},      32'd1);
         chk("hold_busy",      {31'd0, bus.busy},      32'd0);
         chk("hold_quotient",  {26'd0, bus.quotient},  32'd14);
         chk("hold_remainder", {26'd0, bus.remainder}, 32'd2);
         @(negedge clk);
      end

      issue("d45_0", 12'd45, 6'd0, 1'b1, 6'd63, 6'd45, 1'b1, 1'b0, 1);
      wait_done("d45_0", 4);

      issue("d4095_63", 12'd4095, 6'd63, 1'b1, 6'd63, 6'd0, 1'b0, 1'b1, 1);
      wait_done("d4095_63", 4);

      issue("abort", 12'd100, 6'd7, 1'b0, 6'd0, 6'd0, 1'b0, 1'b0, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk_zero("abort");
      rst = 1'b0;

      issue("d50_5", 12'd50, 6'd5, 1'b1, 6'd10, 6'd0, 1'b0, 1'b0, 6);
      wait_done("d50_5", 12);

      issue("ign_load", 12'd100, 6'd7, 1'b1, 6'd14, 6'd2, 1'b0, 1'b0, 6);
      bus.load     = 1'b1;
      bus.dividend = 12'd200;
      bus.divisor  = 6'd9;
      @(negedge clk);
      bus.load = 1'b0;
      wait_done("ign_load", 12);

      bus.load     = 1'b1;
      bus.dividend = 12'd100;
      bus.divisor  = 6'd7;
      rst          = 1'b1;
      @(negedge clk);
      chk_zero("rst_load");
      rst      = 1'b0;
      bus.load = 1'b0;
      repeat (2) @(negedge clk);
      chk_zero("rst_load_idle");

      chk("sb_empty", sb.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/unsigned_seq_div_rs.md
Name: unsigned_seq_div_rs

Overview:
Unsigned sequential restoring divider (shift-and-subtract), one quotient bit per clock. It is the inverse datapath to the team's unsigned sequential shift-add multiplier: it takes a 2*WIDTH-bit product-sized dividend and a WIDTH-bit divisor, and returns a WIDTH-bit quotient and a WIDTH-bit remainder. It uses the same load-and-poll style as the multiplier, with results held until the next load.

Parameters:
WIDTH, 6, divisor/quotient/remainder width; dividend is 2*WIDTH bits.
CW, $clog2(WIDTH+1), iteration counter width (derived localparam, not overridable).

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous reset, active-high
load  input  1  start request; sampled on clk rising edge
dividend  input  2*WIDTH  unsigned dividend
divisor  input  WIDTH  unsigned divisor
quotient  output  WIDTH  quotient, valid while done=1
remainder  output  WIDTH  remainder, valid while done=1
busy  output  1  iteration in progress
done  output  1  result valid; level signal, held until next accepted load or rst
div_by_zero  output  1  last op had divisor==0
overflow  output  1  last op had dividend[2W-1:W] >= divisor (quotient does not fit)

Behaviour:
- Reset values: quotient=0, remainder=0, busy=0, done=0, div_by_zero=0, overflow=0. State=IDLE, counter=0.
- Priority: rst over load. rst=1 with load=1 resets and drops the load.
- States: IDLE, RUN, DONE (2-bit encoding).
- IDLE/DONE + load:
  - Clear done, div_by_zero and overflow.
  - If divisor==0: go to CHECKED-DONE path.
  - Else if hi=dividend[2W-1:W] >= divisor: go to CHECKED-DONE path.
  - Else: R(W+1 bits)={0,hi}, Q=dividend[W-1:0], D=divisor, counter=WIDTH, busy=1, state=RUN.
- CHECKED-DONE path: takes 1 cycle. The edge after load sets done=1 and state=DONE.
  - Divide by zero: div_by_zero=1, quotient=all ones, remainder=dividend[W-1:0].
  - Overflow: overflow=1, quotient=all ones, remainder=0.
- RUN, each edge:
  - Shift {R,Q} left by 1 and compute T=R-{0,D}.
  - If T is non-negative: R=T, Q[0]=1; else Q[0]=0.
  - Decrement counter.
- Last iteration (counter==1): quotient=Q, remainder=R[W-1:0], busy=0, done=1, state=DONE.
- Latency: for a load sampled at edge N, done rises at edge N+WIDTH (6 cycles by default).
- load while RUN is ignored: no restart, operand registers untouched.
- Operands are captured at load. Input changes afterward have no effect.
- Outputs are stable in DONE until the next accepted load. That load drops done on the following edge.
- rst mid-RUN: abort; all outputs and state return to reset values on that edge.
- Invariant when done=1 and no flag: quotient*divisor+remainder == dividend, and remainder < divisor.

Optional Feature:
SEQ_DIV_DBG_EN
- Defined: adds output ports dbg_count[CW-1:0] (live iteration counter) and dbg_state[1:0] (state encoding), plus a simulation-only check that fires $error if the invariant fails on the done rising edge.
- Undefined: these ports and the check are absent; all other behaviour is identical.

Decomposition:
- Package seq_arith_pkg holds:
  - state localparams ST_IDLE=0, ST_RUN=1, ST_DONE=2;
  - default width constant ARITH_W=6.
  The multiplier may share this package.
- One sub-module, seq_div_step: combinational single iteration. Inputs R, Q, D; outputs next R, next Q. Instantiated once.

Test Plan (WIDTH=6):
- load, dividend=3969, divisor=63 -> 6 cycles after load edge: done=1, quotient=63, remainder=0, no flags. This is the inverse of the 63*63 multiply.
- load, dividend=100, divisor=7 -> busy=1 for 6 cycles, then quotient=14, remainder=2, done held across 3 idle cycles.
- load, dividend=45, divisor=0 -> 1 cycle later: done=1, div_by_zero=1, quotient=63, remainder=45.
- load, dividend=4095, divisor=63 -> 1 cycle later: done=1, overflow=1, quotient=63, remainder=0.
- load 100/7, rst pulsed 3 cycles later -> all outputs 0 next edge. Then load 50/5 -> quotient=10, remainder=0 after 6 cycles.
- load 100/7, then load 200/9 at cycle 2 (ignored); also rst=1 and load=1 together -> first case gives quotient=14, remainder=2; second case stays IDLE with all outputs 0.
